vga_scanout: RTL

- Framebuffer read side of the video path.
- Consumes the position and timing stream from the XGA sync generator (1024x768, 65 MHz).
- Fetches 8-bit RGB332 pixels from read port B of the 256x192 framebuffer BRAM, with each stored pixel scaled 4x4.
- Drives the VGA colour pins with sync signals delayed to stay pixel-aligned.
- The CPU writes the framebuffer through port A; this block only reads.

---
 rtl/vga_scanout.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read side, fetches RGB332 pixels (4x4 replicated) and drives VGA pins.
// Latency: exactly 3 clk from h/v/active/sync inputs to colour and sync pins.
// Backpressure: none; streaming pixel pipeline. Optional vertical scroll under `VGA_SCANOUT_SCROLL_EN.
module vga_scanout #(
   parameter int FB_W       = 256,
   parameter int FB_H       = 192,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 16,
   parameter int POS_W      = 13
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [POS_W-1:0]  h_in,
   input  logic [POS_W-1:0]  v_in,
   input  logic              active_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [7:0]        scroll_row,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [7:0]        bram_dout,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [1:0]        blue,
   output logic              hsync,
   output logic              vsync
);

   localparam int COL_W = $clog2(FB_W);
   localparam int ROW_W = $clog2(FB_H);

   logic [POS_W-1:0] col;
   logic [POS_W-1:0] row;
   logic             in_range;
   logic [ROW_W-1:0] row_eff;
   logic             vld1;
   logic             vld2;
   logic [1:0]       hs_sr;
   logic [1:0]       vs_sr;

   // Downscale the raster position and reject anything outside the framebuffer.
   always_comb begin
      col      = h_in >> SCALE_LOG2;
      row      = v_in >> SCALE_LOG2;
      in_range = (32'(col) < FB_W) && (32'(row) < FB_H);
   end

`ifdef VGA_SCANOUT_SCROLL_EN
   localparam logic [ROW_W:0] FB_H_R = (ROW_W+1)'(FB_H);

   logic [ROW_W-1:0] shadow;
   logic [ROW_W-1:0] shadow_new;
   logic [ROW_W-1:0] shadow_use;
   logic             frame_start;
   logic [ROW_W:0]   row_sum;

   // Scrolled row with wrap; the frame's first pixel already uses the newly latched offset.
   always_comb begin
      frame_start = (h_in == '0) && (v_in == '0);
      shadow_new  = (32'(scroll_row) >= FB_H) ? '0 : ROW_W'(scroll_row);
      shadow_use  = frame_start ? shadow_new : shadow;
      row_sum     = {1'b0, row[ROW_W-1:0]} + {1'b0, shadow_use};
      row_eff     = (row_sum >= FB_H_R) ? ROW_W'(row_sum - FB_H_R) : row_sum[ROW_W-1:0];
   end

   // Offset only changes at frame start so a frame is never torn.
   always_ff @(posedge clk) begin
      if (!resetn)
         shadow <= '0;
      else if (frame_start)
         shadow <= shadow_new;
   end
`else
   logic unused_scroll;
   assign unused_scroll = ^scroll_row;

   // No scrolling: row maps straight through.
   always_comb begin
      row_eff = row[ROW_W-1:0];
   end
`endif

   // S1: issue the BRAM address; it holds during blanking and out-of-range positions.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bram_addr <= '0;
         vld1      <= 1'b0;
      end else begin
         vld1 <= active_in && in_range;
         if (active_in && in_range)
            bram_addr <= ADDR_W'({row_eff, col[COL_W-1:0]});
      end
   end

   // S2/S3: track pixel validity alongside the BRAM read, then register colour and aligned syncs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld2  <= 1'b0;
         hs_sr <= 2'b11;
         vs_sr <= 2'b11;
         red   <= '0;
         green <= '0;
         blue  <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         vld2  <= vld1;
         hs_sr <= {hs_sr[0], hsync_in};
         vs_sr <= {vs_sr[0], vsync_in};
         hsync <= hs_sr[1];
         vsync <= vs_sr[1];
         if (vld2) begin
            red   <= bram_dout[7:5];
            green <= bram_dout[4:2];
            blue  <= bram_dout[1:0];
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

endmodule
